// File: rtl/led_sweep_if.sv
// led_sweep_if: debounced button inputs and LED-bar status of the sweep controller.
interface led_sweep_if #(parameter int N_LED = 16);
    localparam int LW = $clog2(N_LED + 1);
    logic start, flick;
    logic [N_LED-1:0] led;
    logic [LW-1:0] level;
    logic [2:0] mode;
    logic up_down, busy, done;
    modport master(output start, flick, input led, level, mode, up_down, busy, done);
    modport slave(input start, flick, output led, level, mode, up_down, busy, done);
endinterface

// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: four-phase up/down thermometer sweep with flick-triggered kickback
// at the lower breakpoint (M2 dwell or M4 pass-through).
module led_sweep_ctrl #(
    parameter int N_LED = 16,
    parameter int BP1 = 5,
    parameter int BP2 = 10,
    parameter int TICK_DIV = 1
) (
    input logic clk,
    input logic rst,
    led_sweep_if.slave bus
);
    localparam int LW = $clog2(N_LED + 1);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, M1, M2, M3, M4} state_t;

    state_t state, state_n;
    logic [LW-1:0] level, level_n, target;
    logic [CW-1:0] cnt, cnt_n;
    logic pend, pend_n, done_r, done_n, step, kick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            level <= '0;
            cnt <= '0;
            pend <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            cnt <= cnt_n;
            pend <= pend_n;
            done_r <= done_n;
        end
    end

    // a flick arriving in the consuming clock is absorbed by that kickback
    always_comb begin
        target = state == M1 ? LW'(N_LED) : state == M2 ? LW'(BP1) : state == M3 ? LW'(BP2) : '0;
        step = state != IDLE && cnt == CW'(TICK_DIV - 1);
        kick = pend | bus.flick;
        state_n = state;
        level_n = level;
        cnt_n = state == IDLE || step ? '0 : cnt + 1'b1;
        pend_n = state != IDLE && kick;
        done_n = 1'b0;
        if (state == IDLE) begin
            if (bus.start) begin
                state_n = M1;
                level_n = '0;
            end
        end else if (step) begin
            if (level != target) begin
                if (state == M4 && level == LW'(BP1) && kick) begin
                    state_n = M3;
                    pend_n = 1'b0;
                end else begin
                    level_n = (state == M1 || state == M3) ? level + 1'b1 : level - 1'b1;
                end
            end else begin
                case (state)
                    M1: state_n = M2;
                    M2: begin
                        state_n = kick ? M1 : M3;
                        pend_n = 1'b0;
                    end
                    M3: state_n = M4;
                    default: begin
                        state_n = IDLE;
                        done_n = 1'b1;
                        pend_n = 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_led
        assign bus.led[i] = LW'(i) < level;
    end

    assign bus.level = level;
    assign bus.mode = state;
    assign bus.up_down = state == M1 || state == M3;
    assign bus.busy = state != IDLE;
    assign bus.done = done_r;
endmodule

// File: doc/led_sweep_ctrl.md
# led_sweep_ctrl

Parametrised, fully synchronous LED sweep controller that drives an N_LED-wide thermometer bar through a four-phase up/down sequence with flick-triggered kickback at a breakpoint. It replaces the earlier edge-triggered mode-only logic: mode sequencing, level counting, step pacing and direction output now live in one clocked block. It sits between the debounced button inputs (start, flick) and the LED output pins.

## Interface

- N_LED, 16, number of LEDs; level range 0..N_LED
- BP1, 5, lower breakpoint; 0 < BP1 < BP2
- BP2, 10, upper breakpoint; BP2 < N_LED
- TICK_DIV, 1, clocks per level step; ≥1
- LW, $clog2(N_LED+1), level width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin sequence; sampled only in IDLE
- flick  in  1  kickback request; synchronous level, sampled every clock
- led  out  N_LED  thermometer: led[i] = (i < level)
- level  out  LW  number of lit LEDs
- mode  out  3  current phase: 0 IDLE, 1 M1, 2 M2, 3 M3, 4 M4
- up_down  out  1  1 while mode is M1 or M3, else 0
- busy  out  1  mode != IDLE
- done  out  1  one-cycle pulse on normal completion

## Operation

- Phases and targets: M1 up to N_LED; M2 down to BP1; M3 up to BP2; M4 down to 0.
- Step: a clock where tick counter cnt == TICK_DIV-1 (every clock when TICK_DIV=1). cnt counts 0..TICK_DIV-1, wraps, held at 0 in IDLE, cleared when start accepted.
- On a step: if level != target, level moves ±1 toward target, mode unchanged. If level == target, level unchanged and mode transitions (one dwell step at each target).
- Transitions at target: M1→M2; M2→M3, or M2→M1 if kickback; M3→M4; M4→IDLE with done=1 for that clock.
- Kickback in M4: on a step where level == BP1 while moving down, if kickback, mode→M3 and level unchanged; otherwise level continues down.
- Kickback = flick_pending OR flick in that clock. flick_pending sets on any busy clock with flick=1; cleared by a kickback consumption (a flick in the consuming clock is consumed too, not left pending) and on entry to IDLE.
- Flick in IDLE ignored. start while busy ignored. start in IDLE: next edge mode=M1, level=0, cnt=0.
- Arithmetic: level is unsigned LW bits; never leaves 0..N_LED (no wrap).

## Timing

- Reset (async, immediate): mode=0, level=0, led=0, up_down=0, busy=0, done=0, cnt=0, flick_pending=0.
- All outputs registered or decoded from registers; no combinational path from inputs to outputs.
- Start latency: start sampled at edge E → mode=1, busy=1, up_down=1 after E; first level increment at E+TICK_DIV.
- Normal sequence length, TICK_DIV=1, defaults: start edge 0; level 1..16 at edges 1..16; M2 at 17; level 15..5 at 18..28; M3 at 29; level 6..10 at 30..34; M4 at 35; level 9..0 at 36..45; IDLE with done at 46. Total steps after start = 2·N_LED + 2·BP2 − 2·BP1 + 4 ... (46 for defaults).
- rst mid-sequence: return to reset values immediately; sequence resumes only on a new start after rst deasserts.

## Test plan

- Reset/idle: assert rst mid-M2 at level 12 → led=0, mode=0, busy=0 at once; flick pulses in IDLE → no state change.
- Normal run, defaults, TICK_DIV=1: start at edge 0 → level trace matches Timing list, done high only at edge 46, up_down=1 exactly in M1/M3.
- M2 kickback: flick pulse at edge 20 (level 13 in M2) → at edge 29 mode→M1, level stays 5, then climbs to 16; flick_pending cleared; next M2 at BP1 with no flick → M3.
- M4 kickback: flick held high at edge 40 (level 5, M4) → mode→M3 at that step, level 5 then 6..10; without flick → level passes 5 to 4.
- Pacing: TICK_DIV=4, N_LED=8, BP1=2, BP2=5 → level changes only every 4th clock; start-ignored-while-busy pulse causes no restart; done after 4·(2·8+2·5−2·2+4)=4·26 clocks (adjust to formula).
- Flick/consumption collision: flick asserted exactly on consuming step → one kickback only; following breakpoint proceeds normally.
